// File: rtl/arbitro_vc_d_if.sv
// Signal bundle between the VC0/VC1 FIFOs, the D0/D1 FIFOs and the VC-to-destination arbiter.
// The master side is the arbiter; the slave side is the FIFO environment around it.
interface arbitro_vc_d_if #(
    parameter int BW = 6,
    parameter int CW = 5
);
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_data_out;
    logic [BW-1:0] VC1_data_out;
    logic          D0_pause;
    logic          D1_pause;
    logic          VC0_rd;
    logic          VC1_rd;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] D0_data_in;
    logic [BW-1:0] D1_data_in;
    logic [CW-1:0] cnt_D0;
    logic [CW-1:0] cnt_D1;

    modport master (
        input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out, D0_pause, D1_pause,
        output VC0_rd, VC1_rd, D0_wr, D1_wr, D0_data_in, D1_data_in, cnt_D0, cnt_D1
    );

    modport slave (
        output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out, D0_pause, D1_pause,
        input  VC0_rd, VC1_rd, D0_wr, D1_wr, D0_data_in, D1_data_in, cnt_D0, cnt_D1
    );
endinterface

// File: rtl/arbitro_vc_d.sv
// Strict-priority (VC0 > VC1) transfer stage from the virtual-channel FIFOs to the D0/D1
// destination FIFOs, with per-destination pause, one-cycle registered push and delivery counters.
module arbitro_vc_d #(
    parameter int BW = 6,
    parameter int CW = 5
) (
    input  logic           clk,
    input  logic           reset_L,
    arbitro_vc_d_if.master bus
);
    logic          vc0_dst;
    logic          vc1_dst;
    logic          vc0_eligible;
    logic          vc1_eligible;
    logic          vc0_rd;
    logic          vc1_rd;
    logic          pop_valid;
    logic          pop_dst;
    logic [BW-1:0] pop_word;

    logic          d0_wr_d;
    logic          d0_wr_q;
    logic          d1_wr_d;
    logic          d1_wr_q;
    logic [BW-1:0] d0_data_d;
    logic [BW-1:0] d0_data_q;
    logic [BW-1:0] d1_data_d;
    logic [BW-1:0] d1_data_q;
    logic [CW-1:0] cnt_d0_d;
    logic [CW-1:0] cnt_d0_q;
    logic [CW-1:0] cnt_d1_d;
    logic [CW-1:0] cnt_d1_q;

    // A blocked VC0 head lets VC1 through only when VC1's own destination is free.
    always_comb begin
        vc0_dst      = bus.VC0_data_out[BW-2];
        vc1_dst      = bus.VC1_data_out[BW-2];
        vc0_eligible = !bus.VC0_empty && !(vc0_dst ? bus.D1_pause : bus.D0_pause);
        vc1_eligible = !bus.VC1_empty && !(vc1_dst ? bus.D1_pause : bus.D0_pause);
        vc0_rd       = reset_L && vc0_eligible;
        vc1_rd       = reset_L && !vc0_eligible && vc1_eligible;
        pop_valid    = vc0_rd || vc1_rd;
        pop_word     = vc0_rd ? bus.VC0_data_out : bus.VC1_data_out;
        pop_dst      = vc0_rd ? vc0_dst : vc1_dst;
    end

    always_comb begin
        d0_wr_d   = pop_valid && !pop_dst;
        d1_wr_d   = pop_valid && pop_dst;
        d0_data_d = d0_wr_d ? pop_word : d0_data_q;
        d1_data_d = d1_wr_d ? pop_word : d1_data_q;
        cnt_d0_d  = d0_wr_d ? cnt_d0_q + CW'(1) : cnt_d0_q;
        cnt_d1_d  = d1_wr_d ? cnt_d1_q + CW'(1) : cnt_d1_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0_wr_q   <= 1'b0;
            d1_wr_q   <= 1'b0;
            d0_data_q <= '0;
            d1_data_q <= '0;
            cnt_d0_q  <= '0;
            cnt_d1_q  <= '0;
        end else begin
            d0_wr_q   <= d0_wr_d;
            d1_wr_q   <= d1_wr_d;
            d0_data_q <= d0_data_d;
            d1_data_q <= d1_data_d;
            cnt_d0_q  <= cnt_d0_d;
            cnt_d1_q  <= cnt_d1_d;
        end
    end

    assign bus.VC0_rd     = vc0_rd;
    assign bus.VC1_rd     = vc1_rd;
    assign bus.D0_wr      = d0_wr_q;
    assign bus.D1_wr      = d1_wr_q;
    assign bus.D0_data_in = d0_data_q;
    assign bus.D1_data_in = d1_data_q;
    assign bus.cnt_D0     = cnt_d0_q;
    assign bus.cnt_D1     = cnt_d1_q;
endmodule

// File: tb/tb_arbitro_vc_d.sv
// Bench for arbitro_vc_d: a combinational selection table, then queue-modelled VC FIFOs
// feeding a scoreboard of expected pushes and counters for the multi-cycle sequences.
module tb_arbitro_vc_d;
    localparam int BW = 6;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset_L;

    arbitro_vc_d_if #(.BW(BW), .CW(CW)) bus ();

    arbitro_vc_d #(.BW(BW), .CW(CW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          e0;
        logic          e1;
        logic [BW-1:0] w0;
        logic [BW-1:0] w1;
        logic          p0;
        logic          p1;
        logic          rd0;
        logic          rd1;
    } vec_t;

    typedef struct {
        logic          wr0;
        logic          wr1;
        logic [BW-1:0] d0;
        logic [BW-1:0] d1;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
    } exp_t;

    vec_t          vecs[10];
    exp_t          exp_q[$];
    logic [BW-1:0] vc0_q[$];
    logic [BW-1:0] vc1_q[$];
    logic [BW-1:0] m_d0;
    logic [BW-1:0] m_d1;
    logic [CW-1:0] m_c0;
    logic [CW-1:0] m_c1;
    logic          cur_p0;
    logic          cur_p1;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Empty FIFOs present junk on their data bus so an illegal pop would be visible.
    task automatic driveInputs();
        bus.D0_pause     = cur_p0;
        bus.D1_pause     = cur_p1;
        bus.VC0_empty    = (vc0_q.size() == 0);
        bus.VC1_empty    = (vc1_q.size() == 0);
        bus.VC0_data_out = (vc0_q.size() != 0) ? vc0_q[0] : 6'h3f;
        bus.VC1_data_out = (vc1_q.size() != 0) ? vc1_q[0] : 6'h3f;
    endtask

    task automatic applyStimulus(input logic p0, input logic p1);
        @(posedge clk);
        #1;
        cur_p0 = p0;
        cur_p1 = p1;
        driveInputs();
    endtask

    task automatic checkOutput();
        exp_t          e;
        exp_t          nxt;
        logic          el0;
        logic          el1;
        logic          rd0;
        logic          rd1;
        logic [BW-1:0] w;
        #3;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("D0_wr", 32'(bus.D0_wr), 32'(e.wr0));
            check("D1_wr", 32'(bus.D1_wr), 32'(e.wr1));
            check("D0_data_in", 32'(bus.D0_data_in), 32'(e.d0));
            check("D1_data_in", 32'(bus.D1_data_in), 32'(e.d1));
            check("cnt_D0", 32'(bus.cnt_D0), 32'(e.c0));
            check("cnt_D1", 32'(bus.cnt_D1), 32'(e.c1));
        end
        el0 = (vc0_q.size() != 0) && !(vc0_q[0][BW-2] ? cur_p1 : cur_p0);
        el1 = (vc1_q.size() != 0) && !(vc1_q[0][BW-2] ? cur_p1 : cur_p0);
        rd0 = el0;
        rd1 = !el0 && el1;
        check("VC0_rd", 32'(bus.VC0_rd), 32'(rd0));
        check("VC1_rd", 32'(bus.VC1_rd), 32'(rd1));
        nxt.wr0 = 1'b0;
        nxt.wr1 = 1'b0;
        if (rd0 || rd1) begin
            w = rd0 ? vc0_q.pop_front() : vc1_q.pop_front();
            if (w[BW-2]) begin
                nxt.wr1 = 1'b1;
                m_d1    = w;
                m_c1    = m_c1 + 5'd1;
            end else begin
                nxt.wr0 = 1'b1;
                m_d0    = w;
                m_c0    = m_c0 + 5'd1;
            end
        end
        nxt.d0 = m_d0;
        nxt.d1 = m_d1;
        nxt.c0 = m_c0;
        nxt.c1 = m_c1;
        exp_q.push_back(nxt);
    endtask

    task automatic run(input int n, input logic p0, input logic p1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(p0, p1);
            checkOutput();
        end
    endtask

    // Asserts reset between edges, checks the immediate clear, then releases just after an edge.
    task automatic resetSequence(input logic preload, input logic [BW-1:0] word);
        #1;
        reset_L = 1'b0;
        vc0_q.delete();
        vc1_q.delete();
        if (preload) vc0_q.push_back(word);
        cur_p0 = 1'b0;
        cur_p1 = 1'b0;
        driveInputs();
        #1;
        check("rst_D0_wr", 32'(bus.D0_wr), 32'd0);
        check("rst_D1_wr", 32'(bus.D1_wr), 32'd0);
        check("rst_D0_data", 32'(bus.D0_data_in), 32'd0);
        check("rst_D1_data", 32'(bus.D1_data_in), 32'd0);
        check("rst_cnt_D0", 32'(bus.cnt_D0), 32'd0);
        check("rst_cnt_D1", 32'(bus.cnt_D1), 32'd0);
        check("rst_VC0_rd", 32'(bus.VC0_rd), 32'd0);
        check("rst_VC1_rd", 32'(bus.VC1_rd), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        m_d0 = '0;
        m_d1 = '0;
        m_c0 = '0;
        m_c1 = '0;
        exp_q.delete();
        exp_q.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 5'd0});
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 6'h00, 6'h3f, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 6'h10, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 6'h00, 6'h10, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 6'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 6'h3f, 6'h3f, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 6'h30, 6'h10, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 6'h25, 6'h3f, 1'b0, 1'b1, 1'b1, 1'b0};

        reset_L = 1'b0;
        cur_p0  = 1'b0;
        cur_p1  = 1'b0;
        m_d0    = '0;
        m_d1    = '0;
        m_c0    = '0;
        m_c1    = '0;
        driveInputs();
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.VC0_empty    = vecs[i].e0;
            bus.VC1_empty    = vecs[i].e1;
            bus.VC0_data_out = vecs[i].w0;
            bus.VC1_data_out = vecs[i].w1;
            bus.D0_pause     = vecs[i].p0;
            bus.D1_pause     = vecs[i].p1;
            #3;
            check($sformatf("vec%0d_VC0_rd", i), 32'(bus.VC0_rd), 32'(vecs[i].rd0));
            check($sformatf("vec%0d_VC1_rd", i), 32'(bus.VC1_rd), 32'(vecs[i].rd1));
        end

        $display("[TB] reset with VC0 holding a word");
        resetSequence(1'b1, 6'b11_0001);
        run(2, 1'b0, 1'b0);

        $display("[TB] routing");
        resetSequence(1'b0, 6'h00);
        vc0_q.push_back(6'b10_0101);
        vc0_q.push_back(6'b11_1100);
        run(4, 1'b0, 1'b0);

        $display("[TB] priority");
        vc0_q.push_back(6'b00_0001);
        vc0_q.push_back(6'b01_0010);
        vc0_q.push_back(6'b00_0011);
        vc1_q.push_back(6'b01_0100);
        vc1_q.push_back(6'b00_0101);
        vc1_q.push_back(6'b01_0110);
        run(8, 1'b0, 1'b0);

        $display("[TB] bypass");
        vc0_q.push_back(6'b01_0011);
        vc1_q.push_back(6'b00_0111);
        vc1_q.push_back(6'b00_0110);
        run(1, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0);

        $display("[TB] pause during push");
        vc0_q.push_back(6'b00_1010);
        vc0_q.push_back(6'b00_1011);
        run(1, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);

        $display("[TB] counter wrap");
        resetSequence(1'b0, 6'h00);
        for (int i = 0; i < 32; i++) vc0_q.push_back(6'($urandom_range(0, 15)));
        run(34, 1'b0, 1'b0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) vc0_q.push_back(6'h10 | 6'(i));
        run(2, 1'b0, 1'b0);
        resetSequence(1'b0, 6'h00);
        run(2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbitro_vc_d.md
Name: arbitro_vc_d

Overview:
- Transfer stage between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the PCIe QoS path.
- Pops one word per cycle from a VC FIFO with strict priority VC0 > VC1.
- Routes each word to D0 or D1 by its destination bit and pushes it one cycle later.
- Honours per-destination almost-full (pause) flags and counts words delivered to each destination.

Parameters:
- BW, 6, word width; bit BW-1 is class (already used upstream), bit BW-2 is destination (0 = D0, 1 = D1).
- CW, 5, width of the per-destination delivery counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- VC0_empty  input  1  VC0 FIFO empty.
- VC1_empty  input  1  VC1 FIFO empty.
- VC0_data_out  input  BW  VC0 head word (first-word-fall-through; valid while !VC0_empty).
- VC1_data_out  input  BW  VC1 head word (first-word-fall-through).
- D0_pause  input  1  D0 almost-full, driven by the D0 high threshold.
- D1_pause  input  1  D1 almost-full.
- VC0_rd  output  1  pop VC0, combinational.
- VC1_rd  output  1  pop VC1, combinational.
- D0_wr  output  1  push D0, registered.
- D1_wr  output  1  push D1, registered.
- D0_data_in  output  BW  word to D0, registered.
- D1_data_in  output  BW  word to D1, registered.
- cnt_D0  output  CW  words pushed to D0 since reset, registered.
- cnt_D1  output  CW  words pushed to D1 since reset, registered.

Behaviour:
- Reset (reset_L = 0, asynchronous): D0_wr, D1_wr, D0_data_in, D1_data_in, cnt_D0 and cnt_D1 all go to 0 immediately.
  - VC0_rd and VC1_rd are forced to 0 while reset_L = 0.
- Destination of a head word: dst = data[BW-2].
- A head is eligible when its FIFO is not empty and the pause flag of its destination is 0.
- Selection, combinational each cycle:
  - If the VC0 head is eligible, VC0_rd = 1 and VC1_rd = 0.
  - Else if the VC1 head is eligible, VC1_rd = 1.
  - Else both are 0.
  - At most one pop per cycle.
- VC1 may bypass a VC0 head that is blocked by a pause flag, provided VC1's own destination is not paused. VC0 keeps priority as soon as its destination unpauses.
- Push, one cycle after the pop:
  - On the edge ending a pop cycle, the popped word is registered into Dx_data_in of its destination, and Dx_wr = 1 for exactly that following cycle.
  - The other destination's wr = 0.
- Data hold: Dx_data_in holds its last value when Dx_wr = 0; it is not cleared.
- Pop-to-push latency is exactly 1 cycle. Back-to-back pops give back-to-back pushes: one word per cycle sustained.
- Pause is sampled only in the pop cycle.
  - A word already popped is always pushed, even if pause rises in the push cycle.
  - The almost-full threshold of the D FIFOs provides at least 1 entry of slack for this.
- Counters:
  - cnt_Dx increments by 1 on every edge on which Dx_wr is being registered to 1.
  - They wrap modulo 2^CW (31 -> 0) with no saturation flag.
- Both VCs empty, or both heads blocked: no pop, and Dx_wr drops to 0 on the next edge.
- Reset asserted mid-transfer: a pending push is discarded and counters clear. After reset_L rises, the first pop can occur in the first cycle.
- Never pop a FIFO whose empty = 1, even if its data bus is non-zero.

Test Plan:
- Reset check: hold reset_L = 0 with VC0 holding 6'b11_0001 -> all outputs 0, VC0_rd = 0; after release, VC0_rd = 1 in the first cycle.
- Routing: VC0 holds 6'b10_0101 then 6'b11_1100, no pause -> D0_wr with D0_data_in = 6'b10_0101 in cycle N+1, then D1_wr with 6'b11_1100 in cycle N+2; cnt_D0 = 1, cnt_D1 = 1.
- Priority: VC0 and VC1 both non-empty, 3 words each -> three VC0 pops first, then three VC1 pops; pushes keep that order.
- Bypass: VC0 head targets D1 with D1_pause = 1; VC1 head targets D0 -> VC1_rd = 1 and VC0_rd = 0. When D1_pause falls, VC0 wins the next cycle.
- Pause during push: pop a D0 word, raise D0_pause in the push cycle -> D0_wr = 1 still occurs, and no further pops target D0.
- Wrap: push 32 words to D0 -> cnt_D0 reads 31 after the 31st push and 0 after the 32nd; assert reset mid-stream -> counters are 0 immediately.
